loadstore_unit: RTL

Load/store initiator sitting between the processor datapath and the word-addressed data memory. Accepts one byte/half/word load or store request at a time, drives the memory's enable, read/write, address and write-data lines, captures read data after a fixed latency, and returns sign/zero-extended load data with a one-cycle response pulse. Sub-word stores are done as read-modify-write because the memory only stores whole 32-bit words. Holds `stall` high while busy so the pipeline freezes.

---
 rtl/loadstore_unit_if.sv | 37 +++
 rtl/loadstore_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/loadstore_unit_if.sv
// Request/response and data-memory bundle of the load/store unit.
// The slave view belongs to the unit itself; the master view is the
// processor and memory side that issues requests and answers reads.
interface loadstore_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall,
    output mem_en, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall,
    input  mem_en, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/loadstore_unit.sv
// Load/store initiator for a word-addressed data memory.
// Handles one byte/half/word request at a time; sub-word stores are
// performed as read-modify-write since the memory only holds whole words.
// Every output is a flop so the memory and pipeline see clean signals.
module loadstore_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  loadstore_unit_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int             CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] rd_cnt;

  // Request fields kept for the whole operation; the requester may change
  // its inputs as soon as the request has been accepted.
  logic             op_write;
  logic [1:0]       op_size;
  logic             op_signed;
  logic [1:0]       op_lane;
  logic [31:0]      op_wdata;

  logic             ready;
  logic             busy;
  logic             resp_pulse;
  logic [31:0]      resp_data;
  logic             resp_error;
  logic             mem_enable;
  logic             mem_write;
  logic [31:0]      word_index;
  logic [31:0]      write_word;

  // Reserved size, misalignment or an address beyond the memory size.
  function automatic logic bad_request(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] upper;
    upper = addr >> (ADDR_W + 2);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && addr[0]) ||
           ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
           (upper != 32'd0);
  endfunction

  // Shift the addressed little-endian lane down and extend it.
  // Half requests are aligned, so the byte-lane shift also fits halves.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: load_extract = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_extract = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: load_extract = word;
    endcase
  endfunction

  // Replace only the addressed lane of the sampled word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic [31:0] data);
    logic [31:0] lane_mask;
    logic [4:0]  sh;
    sh        = {lane, 3'b000};
    lane_mask = (size == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
    store_merge = (word & ~(lane_mask << sh)) | ((data & lane_mask) << sh);
  endfunction

  // Sequencer: IDLE accepts, RD waits out the memory latency, WR writes one
  // word, RESP pulses the response for a single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rd_cnt     <= '0;
      op_write   <= 1'b0;
      op_size    <= 2'b00;
      op_signed  <= 1'b0;
      op_lane    <= 2'b00;
      op_wdata   <= 32'd0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      resp_pulse <= 1'b0;
      resp_data  <= 32'd0;
      resp_error <= 1'b0;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      word_index <= 32'd0;
      write_word <= 32'd0;
    end else begin
      resp_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_write   <= bus.req_write;
            op_size    <= bus.req_size;
            op_signed  <= bus.req_signed;
            op_lane    <= bus.req_addr[1:0];
            op_wdata   <= bus.req_wdata;
            word_index <= 32'(bus.req_addr[ADDR_W+1:2]);
            ready      <= 1'b0;
            busy       <= 1'b1;
            if (bad_request(bus.req_size, bus.req_addr)) begin
              state      <= ST_RESP;
              resp_pulse <= 1'b1;
              resp_error <= 1'b1;
              resp_data  <= 32'd0;
            end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
              state      <= ST_WR;
              mem_enable <= 1'b1;
              mem_write  <= 1'b1;
              write_word <= bus.req_wdata;
            end else begin
              state      <= ST_RD;
              mem_enable <= 1'b1;
              mem_write  <= 1'b0;
              rd_cnt     <= '0;
            end
          end
        end
        ST_RD: begin
          if (rd_cnt == CNT_LAST) begin
            if (op_write) begin
              state      <= ST_WR;
              mem_write  <= 1'b1;
              write_word <= store_merge(bus.mem_rdata, op_size, op_lane, op_wdata);
            end else begin
              state      <= ST_RESP;
              mem_enable <= 1'b0;
              resp_pulse <= 1'b1;
              resp_error <= 1'b0;
              resp_data  <= load_extract(bus.mem_rdata, op_size, op_lane, op_signed);
            end
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        ST_WR: begin
          state      <= ST_RESP;
          mem_enable <= 1'b0;
          mem_write  <= 1'b0;
          resp_pulse <= 1'b1;
          resp_error <= 1'b0;
          resp_data  <= 32'd0;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.stall      = busy;
  assign bus.resp_valid = resp_pulse;
  assign bus.resp_rdata = resp_data;
  assign bus.resp_err   = resp_error;
  assign bus.mem_en     = mem_enable;
  assign bus.mem_rw     = mem_write;
  assign bus.mem_addr   = word_index;
  assign bus.mem_wdata  = write_word;

endmodule
